serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised bit-serial/digit-serial adder-subtractor with a start/busy/done handshake. Operands are loaded in parallel, then consumed DIGIT bits per clock, least significant first, through a registered carry. Result, carry and signed overflow are held until the next operation. It is the area-lean arithmetic unit for datapaths where latency is cheaper than a full-width adder.

## Interface
- WIDTH, 8, operand/result width in bits; ≥ 2
- DIGIT, 1, bits processed per clock; must divide WIDTH (elaboration error otherwise)
- clk  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference; held until next accepted start
- carry_out  output  1  final carry (for sub: 1 = no borrow)
- overflow  output  1  two's-complement overflow (see Configuration)

## Operation
- States: IDLE, SHIFT, DONE (in shared package). N = WIDTH/DIGIT steps.
- IDLE: start=1 → load A_reg=a, B_reg=(sub ? ~b : b), carry=sub, count=0 → SHIFT. start=0 → stay.
- SHIFT: each cycle sum digit = A_reg[DIGIT-1:0] + B_reg[DIGIT-1:0] + carry; A_reg = {sum_digit, A_reg[WIDTH-1:DIGIT]}; B_reg shifts right by DIGIT, zero fill; carry updated; count increments. On step count==N−1 → DONE.
- On last step also capture carry into MSB (c_msb) from the digit slice.
- DONE: done=1 for exactly one cycle; result=A_reg, carry_out=carry, overflow=c_msb^carry, all registered. start=1 in DONE is accepted exactly as in IDLE (back-to-back); else → IDLE.
- start while busy is ignored; no queuing. a/b/sub changes during SHIFT have no effect.
- result/carry_out/overflow change only on entering DONE; stable otherwise.
- Arithmetic modulo 2^WIDTH; no saturation.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, internal regs cleared. Reset mid-SHIFT aborts; no done pulse. reset_n overrides start on the same edge.
- Start accepted at edge E0 → busy=1 from E0 through edge E0+N; done=1 in the cycle following edge E0+N; busy=0 in that cycle.
- Latency start-to-done: N+1 cycles (N steps, 1 DONE). Throughput with back-to-back start: one result per N+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: c_msb tracked, overflow port driven as above.
- Not defined: c_msb logic removed, overflow tied to 0; port still present so instantiations are unchanged.

## Structure
- Package serial_adder_pkg: state enum (IDLE, SHIFT, DONE), state width constant, helper function for count width ($clog2(N), min 1).
- Sub-module serial_digit_add: combinational DIGIT-bit ripple slice; inputs a_d, b_d, cin; outputs sum_d, cout, c_msb (carry into slice MSB). Top holds FSM, shift registers, counter, output registers.

## Test plan
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, sub=0 → after 9 cycles done=1, result=0x96, carry_out=0, overflow=1; busy high exactly 8 cycles.
- sub=1, a=0x10, b=0x20 → result=0xF0, carry_out=0, overflow=0; a=0x80, b=0x01 → result=0x7F, carry_out=1, overflow=1.
- a=0xFF, b=0x01, sub=0 → result=0x00, carry_out=1, overflow=0; WIDTH=8, DIGIT=4 same vector → done 3 cycles after start.
- start pulsed mid-SHIFT with different a/b → ignored, first result unchanged; start held high in DONE → next op begins, done pulses every 9 cycles.
- reset_n=0 at step 4 of 8 → next cycle busy=0, done=0, result=0; no done pulse; fresh start afterwards completes correctly.
- Build without SERIAL_ADDSUB_OVF_EN: 0x5A+0x3C → overflow=0, result=0x96; random 1000-vector compare vs reference model at DIGIT ∈ {1,2,4,8}.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial adder-subtractor.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that walks 0..n-1; never narrower than one bit.
    function automatic int count_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_digit_add.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its MSB.
module serial_digit_add #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] sum_d,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign sum_d[gi] = a_d[gi] ^ b_d[gi] ^ c[gi];
        assign c[gi+1]   = (a_d[gi] & b_d[gi]) | (c[gi] & (a_d[gi] ^ b_d[gi]));
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Bit/digit-serial adder-subtractor with start/busy/done handshake.
// Define SERIAL_ADDSUB_OVF_EN to track signed overflow; otherwise overflow is tied low.
module serial_addsub
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;

    logic [DIGIT-1:0]       sum_d;
    logic                   slice_cout;
    logic                   slice_c_msb;
    logic [WIDTH+DIGIT-1:0] a_cat;
    logic [WIDTH-1:0]       a_shift;
    logic                   accept;
    logic                   last_step;
    logic                   ovf_step;

    serial_digit_add #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d   (a_reg[DIGIT-1:0]),
        .b_d   (b_reg[DIGIT-1:0]),
        .cin   (carry_reg),
        .sum_d (sum_d),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    // The new digit enters at the top so that after N steps A holds the full result.
    assign a_cat   = {sum_d, a_reg} >> DIGIT;
    assign a_shift = a_cat[WIDTH-1:0];

    assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_step = (state_reg == SHIFT) && (count_reg == LAST_STEP);

`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf_step = slice_c_msb ^ slice_cout;
`else
    logic unused_c_msb;
    assign unused_c_msb = slice_c_msb;
    assign ovf_step     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count_reg == LAST_STEP) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            count_reg     <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            count_reg <= '0;
        end else if (state_reg == SHIFT) begin
            a_reg     <= a_shift;
            b_reg     <= b_reg >> DIGIT;
            carry_reg <= slice_cout;
            count_reg <= count_reg + CW'(1);
            if (last_step) begin
                result_reg    <= a_shift;
                carry_out_reg <= slice_cout;
                overflow_reg  <= ovf_step;
            end
        end
    end

    assign busy      = (state_reg == SHIFT);
    assign done      = (state_reg == DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH=8, DIGIT in {1,2,4,8}.
`timescale 1ns/1ps
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       start_v  [4];
    logic       busy_v   [4];
    logic       done_v   [4];
    logic [7:0] result_v [4];
    logic       cout_v   [4];
    logic       ovf_v    [4];

    int tests_run = 0;
    int tests_failed = 0;

    vec_t vecs [6];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        serial_addsub #(
            .WIDTH (8),
            .DIGIT (1 << gi)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start_v[gi]),
            .sub       (sub),
            .a         (a),
            .b         (b),
            .busy      (busy_v[gi]),
            .done      (done_v[gi]),
            .result    (result_v[gi]),
            .carry_out (cout_v[gi]),
            .overflow  (ovf_v[gi])
        );
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: {overflow, carry, result}
    function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [7:0] yy;
        logic [8:0] full;
        logic       v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {8'b0, s};
        v    = (x[7] == yy[7]) && (full[7] != x[7]);
        return {v, full[8], full[7:0]};
    endfunction

    // One operation on instance idx; poke_at > 0 injects a stray start with new operands mid-SHIFT.
    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                          input logic [7:0] er, input logic ec, input logic ev, input int poke_at);
        int cyc;
        int busy_cnt;
        int lat;
        logic exp_v;
        lat   = (8 >> idx) + 1;
        exp_v = OVF_ON ? ev : 1'b0;
        a = av;
        b = bv;
        sub = sv;
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!done_v[idx] && cyc <= 20) begin
            if (busy_v[idx]) busy_cnt++;
            if (cyc == poke_at) begin
                a = ~av;
                b = 8'h33;
                sub = ~sv;
                start_v[idx] = 1'b1;
            end else if (cyc == poke_at + 1) begin
                start_v[idx] = 1'b0;
            end
            tick();
            cyc++;
        end
        check_value("latency", cyc, lat);
        check_value("busy_cycles", busy_cnt, lat - 1);
        check_value("busy_at_done", 32'(busy_v[idx]), 32'(1'b0));
        check_value("result", 32'(result_v[idx]), 32'(er));
        check_value("carry_out", 32'(cout_v[idx]), 32'(ec));
        check_value("overflow", 32'(ovf_v[idx]), 32'(exp_v));
        $display("[TB] digit=%0d a=%02h %s b=%02h -> result=%02h c=%0b v=%0b latency=%0d",
                 1 << idx, av, sv ? "-" : "+", bv, result_v[idx], cout_v[idx], ovf_v[idx], cyc);
        tick();
        check_value("done_one_cycle", 32'(done_v[idx]), 32'(1'b0));
        check_value("result_hold", 32'(result_v[idx]), 32'(er));
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        int last;
        int dones;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rs;
        logic [9:0] m;

        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, s: 1'b0, r: 8'h96, c: 1'b0, v: 1'b1};
        vecs[1] = '{a: 8'h10, b: 8'h20, s: 1'b1, r: 8'hF0, c: 1'b0, v: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, s: 1'b1, r: 8'h7F, c: 1'b1, v: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'h01, s: 1'b0, r: 8'h00, c: 1'b1, v: 1'b0};
        vecs[4] = '{a: 8'h7F, b: 8'h01, s: 1'b0, r: 8'h80, c: 1'b0, v: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, s: 1'b1, r: 8'h00, c: 1'b1, v: 1'b0};

        reset_n = 1'b0;
        start_v[0] = 1'b1;
        tick();
        tick();
        check_value("reset_busy", 32'(busy_v[0]), 32'(1'b0));
        check_value("reset_done", 32'(done_v[0]), 32'(1'b0));
        check_value("reset_result", 32'(result_v[0]), 32'(8'h00));
        check_value("reset_carry", 32'(cout_v[0]), 32'(1'b0));
        check_value("reset_overflow", 32'(ovf_v[0]), 32'(1'b0));
        start_v[0] = 1'b0;
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].v, 0);

        // DIGIT=4: same 0xFF+0x01 vector, done 3 cycles after start
        run_op(2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);

        // Stray start with different operands mid-SHIFT must not disturb the result
        run_op(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 3);

        // Back-to-back: start held high, done every 9 cycles
        a = 8'h10;
        b = 8'h20;
        sub = 1'b0;
        start_v[0] = 1'b1;
        done_seen = 0;
        last = 0;
        for (int c = 1; c <= 40 && done_seen < 3; c++) begin
            tick();
            if (done_v[0]) begin
                if (done_seen > 0) check_value("b2b_gap", c - last, 9);
                check_value("b2b_result", 32'(result_v[0]), 32'(8'h30));
                $display("[TB] back-to-back done #%0d at cycle %0d result=%02h", done_seen + 1, c, result_v[0]);
                last = c;
                done_seen++;
                if (done_seen == 3) start_v[0] = 1'b0;
            end
        end
        check_value("b2b_count", done_seen, 3);
        tick();
        check_value("b2b_idle", 32'(busy_v[0]), 32'(1'b0));

        // Reset in the middle of SHIFT aborts the operation
        a = 8'hC3;
        b = 8'h11;
        sub = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_value("abort_busy", 32'(busy_v[0]), 32'(1'b0));
        check_value("abort_done", 32'(done_v[0]), 32'(1'b0));
        check_value("abort_result", 32'(result_v[0]), 32'(8'h00));
        dones = 0;
        repeat (12) begin
            tick();
            if (done_v[0]) dones++;
        end
        check_value("abort_no_done", dones, 0);
        $display("[TB] reset mid-SHIFT: busy=%0b result=%02h done pulses afterwards=%0d", busy_v[0], result_v[0], dones);
        run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);

        // Random vectors against the reference model, 250 per DIGIT
        for (int idx = 0; idx < 4; idx++) begin
            for (int n = 0; n < 250; n++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rs = 1'($urandom);
                m  = ref_model(ra, rb, rs);
                run_op(idx, ra, rb, rs, m[7:0], m[8], m[9], 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
